rom_frame_reader: RTL and testbench



---
 rtl/rom_frame_reader_pkg.sv | 24 ++
 rtl/rom_frame_reader_if.sv | 32 +++
 rtl/rom_frame_fifo.sv | 59 +++++
 rtl/rom_frame_reader.sv | 175 +++++++++++++++++
 tb/tb_rom_frame_reader.sv | 381 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_frame_reader_pkg.sv
// Shared types for the ROM frame reader: FSM encoding and the layout of one
// output FIFO entry (flag bits sit directly above the pixel data bits).
package rom_frame_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Flag offsets relative to DATA_WIDTH inside a FIFO entry.
    localparam int FLAG_SOF  = 0;
    localparam int FLAG_EOL  = 1;
    localparam int FLAG_EOF  = 2;
    localparam int NUM_FLAGS = 3;

    // Packed so that {flags_t, data} puts sof at DATA_WIDTH+FLAG_SOF.
    typedef struct packed {
        logic eof;
        logic eol;
        logic sof;
    } flags_t;

endpackage

// File: rtl/rom_frame_reader_if.sv
// Pixel stream leaving the frame reader towards the matching datapath.
interface rom_frame_reader_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_sof;
    logic                  m_eol;
    logic                  m_eof;

    // A beat transfers on a rising edge where m_valid && m_ready. Once m_valid
    // is high, m_data and the flags hold until that edge; m_valid never waits
    // on m_ready, and the flags mean nothing while m_valid is low.
    modport master (
        output m_data,
        output m_valid,
        output m_sof,
        output m_eol,
        output m_eof,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_sof,
        input  m_eol,
        input  m_eof,
        output m_ready
    );
endinterface

// File: rtl/rom_frame_fifo.sv
// Synchronous first-word-fall-through FIFO with an occupancy count; the head
// entry is visible on o_rdata whenever o_valid is high.
module rom_frame_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_valid,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_do_push;
    logic w_do_pop;

    assign w_do_pop  = i_pop && (r_count != '0);
    // A full FIFO still accepts a write in the cycle its head is popped.
    assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

endmodule

// File: rtl/rom_frame_reader.sv
// Reads one stored image out of a fixed-latency ROM and streams it as pixels
// with sof/eol/eof markers; a credit check keeps every returning word a slot.
module rom_frame_reader
    import rom_frame_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int IMG_W      = 32,
    parameter int IMG_H      = 32,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_clk_en,
    input  logic [DATA_WIDTH-1:0] rom_rd_data,
    rom_frame_reader_if.master    m_if,
    output state_t                o_dbg_state
);
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = CW + 1;
    localparam int EW = DATA_WIDTH + NUM_FLAGS;

    state_t                r_state;
    logic                  r_busy;
    logic                  r_done;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [XW-1:0]         r_x;
    logic [YW-1:0]         r_y;
    logic [CW-1:0]         r_inflight;
    logic [RD_LATENCY-1:0] r_sr_valid;
    flags_t                r_sr_flags [RD_LATENCY];

    logic          w_issue;
    flags_t        w_issue_flags;
    logic          w_push;
    logic          w_pop;
    logic          w_eof_hs;
    logic [EW-1:0] w_wdata;
    logic [EW-1:0] w_head;
    logic          w_fifo_valid;
    logic [CW-1:0] w_fifo_count;
    logic [SW-1:0] w_used;

    // Every read in flight already owns a FIFO slot, so the ROM pipeline never
    // has to stall mid-read when the consumer stops accepting.
    assign w_used  = {1'b0, r_inflight} + {1'b0, w_fifo_count};
    assign w_issue = (r_state == ST_ISSUE) && (w_used < SW'(FIFO_DEPTH));

    always_comb begin
        w_issue_flags     = '0;
        w_issue_flags.sof = (r_x == '0) && (r_y == '0);
        w_issue_flags.eol = (r_x == XW'(IMG_W - 1));
        w_issue_flags.eof = w_issue_flags.eol && (r_y == YW'(IMG_H - 1));
    end

    // Flags ride alongside the ROM read so they meet their word at the tail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr_valid <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_sr_flags[i] <= '0;
            end
        end else begin
            r_sr_valid[0] <= w_issue;
            r_sr_flags[0] <= w_issue_flags;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_sr_valid[i] <= r_sr_valid[i-1];
                r_sr_flags[i] <= r_sr_flags[i-1];
            end
        end
    end

    assign w_push  = r_sr_valid[RD_LATENCY-1];
    assign w_wdata = {r_sr_flags[RD_LATENCY-1], rom_rd_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
        end else begin
            case ({w_issue, w_push})
                2'b10:   r_inflight <= r_inflight + CW'(1);
                2'b01:   r_inflight <= r_inflight - CW'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    rom_frame_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_valid (w_fifo_valid),
        .o_count (w_fifo_count)
    );

    assign w_pop    = w_fifo_valid && m_if.m_ready;
    assign w_eof_hs = w_pop && w_head[DATA_WIDTH + FLAG_EOF];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_addr  <= '0;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // A start landing in the done cycle belongs to the old frame.
                    if (start && !r_done) begin
                        r_state <= ST_ISSUE;
                        r_busy  <= 1'b1;
                        r_addr  <= '0;
                        r_x     <= '0;
                        r_y     <= '0;
                    end
                end
                ST_ISSUE: begin
                    if (w_issue) begin
                        if (w_issue_flags.eof) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_addr <= r_addr + ADDR_WIDTH'(1);
                        end
                        if (w_issue_flags.eol) begin
                            r_x <= '0;
                            r_y <= w_issue_flags.eof ? '0 : r_y + YW'(1);
                        end else begin
                            r_x <= r_x + XW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_eof_hs) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign rom_addr    = r_addr;
    assign rom_clk_en  = w_issue;
    assign o_dbg_state = r_state;

    assign m_if.m_data  = w_head[DATA_WIDTH-1:0];
    assign m_if.m_valid = w_fifo_valid;
    assign m_if.m_sof   = w_head[DATA_WIDTH + FLAG_SOF];
    assign m_if.m_eol   = w_head[DATA_WIDTH + FLAG_EOL];
    assign m_if.m_eof   = w_head[DATA_WIDTH + FLAG_EOF];

endmodule

// File: tb/tb_rom_frame_reader.sv
// Bench for rom_frame_reader: three instances (4x2 lat 2, 5x3 lat 1, 1x1 lat 2)
// each fed by a ROM model whose word equals its address.
module tb_rom_frame_reader;
    import rom_frame_reader_pkg::*;

    localparam int AW = 10;
    localparam int DW = 32;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- instance A: 4x2, latency 2 ----------------
    logic          start_a = 1'b0;
    logic          busy_a, done_a, clk_en_a;
    logic [AW-1:0] addr_a;
    logic [DW-1:0] rd_a;
    state_t        st_a;
    logic [AW-1:0] rom_a_s0 = '0;
    logic [AW-1:0] rom_a_s1 = '0;
    rom_frame_reader_if #(.DATA_WIDTH(DW)) if_a ();

    always @(posedge clk) begin
        if (clk_en_a) rom_a_s0 <= addr_a;
        rom_a_s1 <= rom_a_s0;
    end
    assign rd_a = {{(DW-AW){1'b0}}, rom_a_s1};

    rom_frame_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IMG_W(4), .IMG_H(2),
                       .RD_LATENCY(2), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
        .rom_addr(addr_a), .rom_clk_en(clk_en_a), .rom_rd_data(rd_a),
        .m_if(if_a), .o_dbg_state(st_a));

    // ---------------- instance B: 5x3, latency 1 ----------------
    logic          start_b = 1'b0;
    logic          busy_b, done_b, clk_en_b;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] rd_b;
    state_t        st_b;
    logic [AW-1:0] rom_b_s0 = '0;
    rom_frame_reader_if #(.DATA_WIDTH(DW)) if_b ();

    always @(posedge clk) begin
        if (clk_en_b) rom_b_s0 <= addr_b;
    end
    assign rd_b = {{(DW-AW){1'b0}}, rom_b_s0};

    rom_frame_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IMG_W(5), .IMG_H(3),
                       .RD_LATENCY(1), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
        .rom_addr(addr_b), .rom_clk_en(clk_en_b), .rom_rd_data(rd_b),
        .m_if(if_b), .o_dbg_state(st_b));

    // ---------------- instance C: 1x1, latency 2 ----------------
    logic          start_c = 1'b0;
    logic          busy_c, done_c, clk_en_c;
    logic [AW-1:0] addr_c;
    logic [DW-1:0] rd_c;
    state_t        st_c;
    logic [AW-1:0] rom_c_s0 = '0;
    logic [AW-1:0] rom_c_s1 = '0;
    rom_frame_reader_if #(.DATA_WIDTH(DW)) if_c ();

    always @(posedge clk) begin
        if (clk_en_c) rom_c_s0 <= addr_c;
        rom_c_s1 <= rom_c_s0;
    end
    assign rd_c = {{(DW-AW){1'b0}}, rom_c_s1};

    rom_frame_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IMG_W(1), .IMG_H(1),
                       .RD_LATENCY(2), .FIFO_DEPTH(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .busy(busy_c), .done(done_c),
        .rom_addr(addr_c), .rom_clk_en(clk_en_c), .rom_rd_data(rd_c),
        .m_if(if_c), .o_dbg_state(st_c));

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [34:0] beat(input int d, input bit sof, input bit eol, input bit eof);
        return {eof, eol, sof, 32'(d)};
    endfunction

    // ---------------- scoreboards ----------------
    logic [34:0] exp_qa[$];
    logic [34:0] exp_qb[$];
    int beats_a = 0, dones_a = 0;
    int beats_b = 0, dones_b = 0;
    int out_b = 0, max_out_b = 0;

    // Inputs change on the falling edge; +2 later they match the next rising edge.
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (if_a.m_valid && if_a.m_ready) begin
                beats_a++;
                if (exp_qa.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL a_extra_beat: got data %0h expected no beat", if_a.m_data);
                end else begin
                    check("a_beat", {if_a.m_eof, if_a.m_eol, if_a.m_sof, if_a.m_data}, exp_qa.pop_front());
                end
            end
            if (done_a) dones_a++;

            if (clk_en_b) out_b++;
            if (if_b.m_valid && if_b.m_ready) begin
                out_b--;
                beats_b++;
                if (exp_qb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL b_extra_beat: got data %0h expected no beat", if_b.m_data);
                end else begin
                    check("b_beat", {if_b.m_eof, if_b.m_eol, if_b.m_sof, if_b.m_data}, exp_qb.pop_front());
                end
            end
            if (out_b > max_out_b) max_out_b = out_b;
            if (done_b) dones_b++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_frame_a();
        for (int d = 0; d < 8; d++) exp_qa.push_back(beat(d, d == 0, (d % 4) == 3, d == 7));
    endtask

    task automatic pulse_start_a();
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    // Leaves the caller 1 time unit into the done cycle.
    task automatic wait_done_a(input string name, input int budget);
        int k = 0;
        while (!done_a && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        check(name, done_a, 1'b1);
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_busy"},   busy_a,       1'b0);
        check({tag, "_done"},   done_a,       1'b0);
        check({tag, "_addr"},   addr_a,       '0);
        check({tag, "_clk_en"}, clk_en_a,     1'b0);
        check({tag, "_valid"},  if_a.m_valid, 1'b0);
        check({tag, "_flags"},  {if_a.m_sof, if_a.m_eol, if_a.m_eof}, 3'b000);
        check({tag, "_data"},   if_a.m_data,  '0);
        check({tag, "_state"},  st_a,         ST_IDLE);
    endtask

    // ---------------- basic-frame vector table ----------------
    typedef struct {
        logic          clk_en;
        logic [AW-1:0] addr;
        logic          valid;
        logic [DW-1:0] data;
        logic          sof, eol, eof, busy, done;
    } vec_t;
    vec_t tab [13];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int issues;
        int base;
        int k;

        // Row c = state seen during the cycle after rising edge c (start at edge 0).
        tab[0]  = '{1'b1, 10'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tab[1]  = '{1'b1, 10'd1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tab[2]  = '{1'b1, 10'd2, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tab[3]  = '{1'b1, 10'd3, 1'b1, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tab[4]  = '{1'b1, 10'd4, 1'b1, 32'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tab[5]  = '{1'b1, 10'd5, 1'b1, 32'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tab[6]  = '{1'b1, 10'd6, 1'b1, 32'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tab[7]  = '{1'b1, 10'd7, 1'b1, 32'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tab[8]  = '{1'b0, 10'd7, 1'b1, 32'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tab[9]  = '{1'b0, 10'd7, 1'b1, 32'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tab[10] = '{1'b0, 10'd7, 1'b1, 32'd7, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tab[11] = '{1'b0, 10'd7, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tab[12] = '{1'b0, 10'd7, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        if_a.m_ready = 1'b1;
        if_b.m_ready = 1'b1;
        if_c.m_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_reset_a("rst0");
        check("rst0_b_valid", if_b.m_valid, 1'b0);
        check("rst0_c_busy", busy_c, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- basic frame, m_ready high ----
        push_frame_a();
        start_a = 1'b1;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            start_a = 1'b0;
            #1;
            check($sformatf("t1_c%0d_clk_en", c), clk_en_a, tab[c].clk_en);
            check($sformatf("t1_c%0d_addr", c),   addr_a,   tab[c].addr);
            check($sformatf("t1_c%0d_valid", c),  if_a.m_valid, tab[c].valid);
            check($sformatf("t1_c%0d_busy", c),   busy_a,   tab[c].busy);
            check($sformatf("t1_c%0d_done", c),   done_a,   tab[c].done);
            if (tab[c].valid) begin
                check($sformatf("t1_c%0d_data", c), if_a.m_data, tab[c].data);
                check($sformatf("t1_c%0d_flags", c), {if_a.m_sof, if_a.m_eol, if_a.m_eof},
                      {tab[c].sof, tab[c].eol, tab[c].eof});
            end
        end
        check("t1_all_beats", exp_qa.size(), 0);

        // ---- backpressure: m_ready low for cycles 0-15 ----
        push_frame_a();
        @(negedge clk);
        if_a.m_ready = 1'b0;
        start_a = 1'b1;
        issues = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            start_a = 1'b0;
            #1;
            if (clk_en_a) issues++;
        end
        check("t2_issue_count", issues, 4);
        check("t2_clk_en_low", clk_en_a, 1'b0);
        check("t2_addr_held", addr_a, 10'd4);
        check("t2_valid_held", if_a.m_valid, 1'b1);
        check("t2_data_held", if_a.m_data, 32'd0);
        check("t2_sof_held", if_a.m_sof, 1'b1);
        if_a.m_ready = 1'b1;
        wait_done_a("t2_done", 40);
        @(negedge clk);
        check("t2_all_beats", exp_qa.size(), 0);

        // ---- stray start pulses mid-frame ----
        push_frame_a();
        dones_a = 0;
        base = beats_a;
        @(negedge clk);
        start_a = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            start_a = (c == 2 || c == 5);
        end
        start_a = 1'b0;
        check("t4_beats", beats_a - base, 8);
        check("t4_done_pulses", dones_a, 1);
        check("t4_queue_empty", exp_qa.size(), 0);

        // ---- start in the done cycle ignored, next cycle accepted ----
        push_frame_a();
        pulse_start_a();
        wait_done_a("t4b_done", 40);
        start_a = 1'b1;
        @(negedge clk);
        #1;
        check("t4b_done_cycle_start_ignored", busy_a, 1'b0);
        check("t4b_no_issue", clk_en_a, 1'b0);
        push_frame_a();
        @(negedge clk);
        start_a = 1'b0;
        #1;
        check("t4b_next_cycle_start_taken", busy_a, 1'b1);
        wait_done_a("t4b_second_done", 40);
        @(negedge clk);
        check("t4b_queue_empty", exp_qa.size(), 0);

        // ---- reset mid-frame after beat 3 ----
        push_frame_a();
        base = beats_a;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        k = 0;
        while (beats_a < base + 4 && k < 30) begin
            @(negedge clk);
            k++;
        end
        check("t5_reached_beat3", beats_a - base, 4);
        rst_n = 1'b0;
        exp_qa.delete();
        #1;
        check_reset_a("t5_rst_a");
        @(negedge clk);
        @(negedge clk);
        #1;
        check_reset_a("t5_rst_b");
        rst_n = 1'b1;
        @(negedge clk);
        push_frame_a();
        pulse_start_a();
        wait_done_a("t5_restart_done", 40);
        @(negedge clk);
        check("t5_restart_all_beats", exp_qa.size(), 0);

        // ---- random m_ready on 5x3, latency 1 ----
        for (int d = 0; d < 15; d++) exp_qb.push_back(beat(d, d == 0, (d % 5) == 4, d == 14));
        beats_b = 0;
        dones_b = 0;
        out_b = 0;
        max_out_b = 0;
        @(negedge clk);
        start_b = 1'b1;
        k = 0;
        while (k < 300) begin
            @(negedge clk);
            start_b = 1'b0;
            if_b.m_ready = 1'($urandom_range(0, 1));
            k++;
            if (dones_b != 0) k = 300;
        end
        if_b.m_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("t3_beats", beats_b, 15);
        check("t3_done_pulses", dones_b, 1);
        check("t3_queue_empty", exp_qb.size(), 0);
        check("t3_credit_bound", max_out_b <= 4, 1'b1);
        check("t3_busy_low", busy_b, 1'b0);

        // ---- degenerate 1x1 frame ----
        @(negedge clk);
        start_c = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            start_c = 1'b0;
            #1;
            case (c)
                0: begin
                    check("t6_c0_busy", busy_c, 1'b1);
                    check("t6_c0_clk_en", clk_en_c, 1'b1);
                    check("t6_c0_addr", addr_c, 10'd0);
                end
                1: begin
                    check("t6_c1_clk_en", clk_en_c, 1'b0);
                    check("t6_c1_state", st_c, ST_DRAIN);
                end
                2: check("t6_c2_valid", if_c.m_valid, 1'b0);
                3: begin
                    check("t6_c3_valid", if_c.m_valid, 1'b1);
                    check("t6_c3_data", if_c.m_data, 32'd0);
                    check("t6_c3_flags", {if_c.m_sof, if_c.m_eol, if_c.m_eof}, 3'b111);
                    check("t6_c3_done", done_c, 1'b0);
                end
                4: begin
                    check("t6_c4_done", done_c, 1'b1);
                    check("t6_c4_busy", busy_c, 1'b0);
                    check("t6_c4_valid", if_c.m_valid, 1'b0);
                end
                default: check("t6_c5_done", done_c, 1'b0);
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
